// File: rtl/aes_128_decrypt.sv
// ---------------------------------------------------------------------------
// aes_128_decrypt
//   Iterative AES-128 inverse cipher (FIPS-197). One operation per clock.
//   The round keys are not stored. The key register first runs forward to
//   round key 10. It then steps backward one round key per round.
//
//   Ports
//     clk          system clock, rising edge
//     reset_n      asynchronous reset, active low
//     valid_in     start request; cipher_key / cipher_text valid
//     ready_in     registered; high only while idle (request accepted)
//     cipher_key   128-bit cipher key (same key as used for encryption)
//     cipher_text  128-bit ciphertext, bit 127 = MSB of byte 0
//     plain_text   registered result, held until the next completion
//     valid_out    one-cycle pulse marking a new plain_text
//
//   Timing: accept at edge N -> KEYEXP (N+1..N+10) -> ADD0 (N+11)
//           -> ROUND x9 (N+12..N+20) -> FINAL (N+21) -> IDLE.
// ---------------------------------------------------------------------------
module aes_128_decrypt #(
  parameter int DATA_W = 128,
  parameter int KEY_L  = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [KEY_L-1:0]  cipher_key,
  input  logic [DATA_W-1:0] cipher_text,
  output logic [DATA_W-1:0] plain_text,
  output logic              valid_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYEXP = 3'd1,
    ADD0   = 3'd2,
    ROUND  = 3'd3,
    FINAL  = 3'd4
  } fsm_t;

  // -------------------------------------------------------------------------
  // GF(2^8) and AES helper functions
  // -------------------------------------------------------------------------

  // Multiply by x modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Divide by x (inverse of xtime). This lets rcon run backward.
  function automatic logic [7:0] inv_xtime(input logic [7:0] a);
    inv_xtime = {1'b0, a[7:1]} ^ (a[0] ? 8'h8d : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      aa = xtime(aa);
    end
    gf_mul = p;
  endfunction

  // Multiplicative inverse as a^254. The inverse of 0 comes out as 0,
  // which is what the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = a;
    res = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    gf_inv = res;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    rotl8 = (x << n) | (x >> (8 - n));
  endfunction

  // Forward S-box: inverse, then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i    = gf_inv(a);
    sbox = i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine transform, then the inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] t;
    t        = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
    inv_sbox = gf_inv(t);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] o;
    o = 32'h0;
    for (int i = 0; i < 4; i++) begin
      o[8*i +: 8] = sbox(w[8*i +: 8]);
    end
    sub_word = o;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

  // Byte i (FIPS order) is at bits [8*(15-i) +: 8]; byte r+4c is row r, column c.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(15 - (r + 4*c)) +: 8] = s[8*(15 - (r + 4*((c - r + 4) % 4))) +: 8];
      end
    end
    inv_shift_rows = o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    end
    inv_sub_bytes = o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(15 - 4*c) +: 8];
      a1 = s[8*(14 - 4*c) +: 8];
      a2 = s[8*(13 - 4*c) +: 8];
      a3 = s[8*(12 - 4*c) +: 8];
      o[8*(15 - 4*c) +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[8*(14 - 4*c) +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[8*(13 - 4*c) +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[8*(12 - 4*c) +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    inv_mix_columns = o;
  endfunction

  // One forward key-schedule step: rk_i -> rk_{i+1}.
  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h000000};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    key_fwd = {w0, w1, w2, w3};
  endfunction

  // One backward key-schedule step: rk_i -> rk_{i-1}. The rcon is the one
  // that was used to derive rk_i.
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0]  ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h000000};
    key_inv = {w0, w1, w2, w3};
  endfunction

  // -------------------------------------------------------------------------
  // Registers and next-state signals
  // -------------------------------------------------------------------------
  fsm_t              fsm_r, fsm_s;
  logic [DATA_W-1:0] blk_r, blk_s;
  logic [KEY_L-1:0]  key_r, key_s;
  logic [3:0]        cnt_r, cnt_s;
  logic [7:0]        rcon_r, rcon_s;
  logic [DATA_W-1:0] pt_r, pt_s;
  logic              vout_r, vout_s;
  logic              ready_r;

  logic [DATA_W-1:0] isr_isb_s;
  logic [KEY_L-1:0]  key_fwd_s;
  logic [KEY_L-1:0]  key_inv_s;

  // Shared datapath. Every state that needs these uses the same form.
  assign isr_isb_s = inv_sub_bytes(inv_shift_rows(blk_r));
  assign key_fwd_s = key_fwd(key_r, rcon_r);
  assign key_inv_s = key_inv(key_r, rcon_r);

  // Next-state and datapath control for the round FSM.
  always_comb begin
    fsm_s  = fsm_r;
    blk_s  = blk_r;
    key_s  = key_r;
    cnt_s  = cnt_r;
    rcon_s = rcon_r;
    pt_s   = pt_r;
    vout_s = 1'b0;
    case (fsm_r)
      IDLE: begin
        if (valid_in) begin
          blk_s  = cipher_text;
          key_s  = cipher_key;
          cnt_s  = 4'd0;
          rcon_s = 8'h01;
          fsm_s  = KEYEXP;
        end else begin
          fsm_s  = IDLE;
        end
      end
      KEYEXP: begin
        key_s = key_fwd_s;
        if (cnt_r == 4'd9) begin
          // Keep rcon at 36. The first backward step needs that value.
          cnt_s = 4'd0;
          fsm_s = ADD0;
        end else begin
          cnt_s  = cnt_r + 4'd1;
          rcon_s = xtime(rcon_r);
        end
      end
      ADD0: begin
        blk_s  = blk_r ^ key_r;
        key_s  = key_inv_s;
        rcon_s = inv_xtime(rcon_r);
        cnt_s  = 4'd0;
        fsm_s  = ROUND;
      end
      ROUND: begin
        blk_s  = inv_mix_columns(isr_isb_s ^ key_r);
        key_s  = key_inv_s;
        rcon_s = inv_xtime(rcon_r);
        if (cnt_r == 4'd8) begin
          cnt_s = 4'd0;
          fsm_s = FINAL;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      FINAL: begin
        pt_s   = isr_isb_s ^ key_r;
        vout_s = 1'b1;
        fsm_s  = IDLE;
      end
      default: begin
        fsm_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers. Reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_r   <= IDLE;
      blk_r   <= {DATA_W{1'b0}};
      key_r   <= {KEY_L{1'b0}};
      cnt_r   <= 4'd0;
      rcon_r  <= 8'h00;
      pt_r    <= {DATA_W{1'b0}};
      vout_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      fsm_r   <= fsm_s;
      blk_r   <= blk_s;
      key_r   <= key_s;
      cnt_r   <= cnt_s;
      rcon_r  <= rcon_s;
      pt_r    <= pt_s;
      vout_r  <= vout_s;
      ready_r <= (fsm_s == IDLE);
    end
  end

  assign plain_text = pt_r;
  assign valid_out  = vout_r;
  assign ready_in   = ready_r;

endmodule

// File: tb/tb_aes_128_decrypt.sv
// ---------------------------------------------------------------------------
// tb_aes_128_decrypt
//   The stimulus pushes the expected plaintext and the expected completion
//   cycle into a queue. A monitor pops and compares on each valid_out.
//   The reference is a forward AES-128 encrypt model. Its S-box comes from
//   the 3 / 1/3 generator walk. Random plaintexts are encrypted with this
//   model and fed to the decryptor.
// ---------------------------------------------------------------------------
module tb_aes_128_decrypt;

  localparam logic [127:0] A_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] A_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] A_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk;
  logic         reset_n;
  logic         valid_in;
  logic         ready_in;
  logic [127:0] cipher_key;
  logic [127:0] cipher_text;
  logic [127:0] plain_text;
  logic         valid_out;

  aes_128_decrypt #(.DATA_W(128), .KEY_L(128)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .valid_in    (valid_in),
    .ready_in    (ready_in),
    .cipher_key  (cipher_key),
    .cipher_text (cipher_text),
    .plain_text  (plain_text),
    .valid_out   (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] pt;
    longint       cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox_t [256];

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [7:0] m2(input logic [7:0] b);
    m2 = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h000000};
        rc  = m2(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r + 4*c] = s[r + 4*((c + r) % 4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
          t[4*c+3] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    o = 128'h0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    aes_enc = o;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid_out", 128'(valid_out), 128'd0);
      end else begin
        e = exp_q.pop_front();
        check("plain_text", plain_text, e.pt);
        check("latency_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Raises valid_in with the vector and waits for the accept edge. It returns
  // right after that edge with valid_in still high.
  task automatic issue(input logic [127:0] key, input logic [127:0] ct,
                       input logic [127:0] pt, input bit push, output longint acc);
    bit   got;
    exp_t e;
    got = 1'b0;
    acc = -1;
    @(negedge clk);
    valid_in    = 1'b1;
    cipher_key  = key;
    cipher_text = ct;
    for (int k = 0; k < 60 && !got; k++) begin
      if (ready_in) begin
        got = 1'b1;
        acc = cyc + 1;
        if (push) begin
          e.pt  = pt;
          e.cyc = cyc + 22;
          exp_q.push_back(e);
        end
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!got) check("accept_timeout", 128'd0, 128'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_queue_empty", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint acc0, acc1, acc2;
    logic [127:0] rk, rp;

    build_sbox();
    reset_n     = 1'b0;
    valid_in    = 1'b0;
    cipher_key  = 128'h0;
    cipher_text = 128'h0;
    repeat (3) @(negedge clk);
    check("reset_ready_in", 128'(ready_in), 128'd1);
    check("reset_valid_out", 128'(valid_out), 128'd0);
    check("reset_plain_text", plain_text, 128'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Known-answer vectors
    issue(A_KEY, A_CT, A_PT, 1'b1, acc0);
    @(negedge clk); valid_in = 1'b0;
    drain();
    issue(B_KEY, B_CT, B_PT, 1'b1, acc0);
    @(negedge clk); valid_in = 1'b0;
    drain();

    // Requests while busy are ignored. ready_in stays low until FINAL has passed.
    issue(A_KEY, A_CT, A_PT, 1'b1, acc0);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k == 4 || k == 14) begin
        valid_in    = 1'b1;
        cipher_key  = {$urandom, $urandom, $urandom, $urandom};
        cipher_text = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        valid_in = 1'b0;
      end
      check("busy_ready_in", 128'(ready_in), 128'd0);
    end
    @(negedge clk);
    check("ready_after_final", 128'(ready_in), 128'd1);
    drain();

    // valid_in held high: a back-to-back accept every 22 cycles
    issue(A_KEY, A_CT, A_PT, 1'b1, acc0);
    issue(B_KEY, B_CT, B_PT, 1'b1, acc1);
    check("b2b_spacing_1", 128'(acc1 - acc0), 128'd22);
    issue(A_KEY, A_CT, A_PT, 1'b1, acc2);
    check("b2b_spacing_2", 128'(acc2 - acc1), 128'd22);
    @(negedge clk); valid_in = 1'b0;
    drain();

    // Reset mid-operation aborts the operation with no valid_out pulse
    issue(A_KEY, A_CT, A_PT, 1'b0, acc0);
    @(negedge clk); valid_in = 1'b0;
    for (int k = 0; k < 30 && cyc < acc0 + 11; k++) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_ready_in", 128'(ready_in), 128'd1);
    check("midreset_plain_text", plain_text, 128'h0);
    check("midreset_valid_out", 128'(valid_out), 128'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    issue(B_KEY, B_CT, B_PT, 1'b1, acc0);
    @(negedge clk); valid_in = 1'b0;
    drain();

    // Random round trips through the encrypt model
    for (int n = 0; n < 1000; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      issue(rk, aes_enc(rk, rp), rp, 1'b1, acc0);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        valid_in = 1'b0;
      end
    end
    @(negedge clk); valid_in = 1'b0;
    drain();

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_128_decrypt.md
AES_128_DECRYPT -- requirements
Module: aes_128_decrypt

Interface
REQ-001 The block SHALL have parameter DATA_W, default 128, meaning data block width in bits (only 128 supported).
REQ-002 The block SHALL have parameter KEY_L, default 128, meaning cipher key width in bits (only 128 supported).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  system clock, rising edge.
REQ-004 reset_n  input  1  asynchronous reset, active low.
REQ-005 valid_in  input  1  request to start a decryption; cipher_key and cipher_text are valid.
REQ-006 ready_in  output  1  block is idle and accepts a request this cycle.
REQ-007 cipher_key  input  KEY_L  AES-128 cipher key, the same key used for encryption.
REQ-008 cipher_text  input  DATA_W  ciphertext block; bit 127 is the MSB of byte 0 (FIPS-197 order).
REQ-009 plain_text  output  DATA_W  registered decryption result.
REQ-010 valid_out  output  1  one-cycle pulse marking a new plain_text.

Function
REQ-011 The block SHALL implement FIPS-197 AES-128 inverse cipher, iterative, one operation per clock, with on-the-fly key schedule (no stored round-key table).
REQ-012 The FSM SHALL have states IDLE, KEYEXP, ADD0, ROUND, FINAL; ready_in SHALL be 1 only in IDLE.
REQ-013 Accept SHALL occur at a rising edge with state IDLE and valid_in=1: capture cipher_key into key register, cipher_text into state register, round counter <= 0, rcon <= 8'h01, go to KEYEXP.
REQ-014 KEYEXP SHALL perform the forward key expansion one round key per cycle for 10 cycles (rcon 01,02,04,08,10,20,40,80,1b,36), ending with key register = round key 10.
REQ-015 ADD0 (1 cycle) SHALL do state <= state ^ rk10 and key <= rk9 via inverse schedule.
REQ-016 Inverse schedule from rk_r (words w0..w3) SHALL be: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^rcon_r; rcon steps backward 36,1b,80,...,01.
REQ-017 ROUND (9 cycles, r=9..1) SHALL do state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_r), and key <= rk_{r-1}.
REQ-018 FINAL (1 cycle) SHALL do plain_text <= InvSubBytes(InvShiftRows(state)) ^ rk0, assert valid_out for exactly one cycle, return to IDLE.
REQ-019 Latency SHALL be fixed: accept at edge N gives valid_out=1 in the cycle following edge N+21; next accept possible at edge N+22 (throughput one block per 22 cycles).
REQ-020 valid_in while not IDLE SHALL be ignored; no queuing, in-flight operation unaffected; input changes after accept SHALL not affect the result.
REQ-021 plain_text SHALL hold its last value until the next FINAL; valid_out SHALL be 0 at all other times.
REQ-022 valid_in held high continuously SHALL start a new operation at every IDLE cycle.

Reset
REQ-023 reset_n=0 SHALL immediately, asynchronously, force FSM to IDLE, plain_text to 0, valid_out to 0, ready_in to 1, and clear state, key, counter, rcon registers.
REQ-024 Reset asserted mid-operation SHALL abort it with no valid_out pulse; first accept after deassertion SHALL behave as from power-up.
REQ-025 valid_in sampled during the edge on which reset_n deasserts SHALL only be accepted if reset_n is high at that edge.

Verification
REQ-026 Key 000102030405060708090a0b0c0d0e0f, cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a -> plain_text 00112233445566778899aabbccddeeff, valid_out pulse after edge N+21.
REQ-027 Key 2b7e151628aed2a6abf7158809cf4f3c, cipher_text 3925841d02dc09fbdc118597196a0b32 -> plain_text 3243f6a8885a308d313198a2e0370734.
REQ-028 Valid_in pulsed with different key/data at N+5 and N+15 during REQ-026 operation -> ignored, result unchanged, ready_in=0 during N+1..N+21.
REQ-029 valid_in held high for 3 blocks (REQ-026, REQ-027, REQ-026 vectors) -> three correct results, valid_out pulses exactly 22 cycles apart.
REQ-030 reset_n low at N+12 for 2 cycles -> plain_text=0, valid_out never pulses, ready_in=1 at once; next REQ-027 run correct.
REQ-031 Random key/plaintext encrypted by the team's AES encrypt model, fed back -> plain_text equals original for 1000 vectors.
